// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle issuing controller for the 8-bit combinational ALU (optional ALU_SEQ_PERF_EN perf counters)
module alu_sequencer #(
    parameter int W   = 8,
    parameter int Ops = 3
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_req_valid,
    output logic           o_req_ready,
    input  logic [Ops-1:0] i_req_op,
    input  logic [W-1:0]   i_req_a,
    input  logic [W-1:0]   i_req_b,
    output logic [Ops-1:0] o_alu_op,
    output logic [W-1:0]   o_alu_a,
    output logic [W-1:0]   o_alu_b,
    output logic           o_alu_sc,
    input  logic [W-1:0]   i_alu_out,
    input  logic           i_alu_zero,
    input  logic           i_alu_parity,
    input  logic           i_alu_odd,
    output logic           o_rsp_valid,
    input  logic           i_rsp_ready,
    output logic [W-1:0]   o_rsp_data,
    output logic           o_rsp_zero,
    output logic           o_rsp_parity,
    output logic           o_rsp_odd,
    output logic           o_rsp_err
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [15:0]    o_op_count,
    output logic [15:0]    o_step_count
`endif
);

    localparam logic [Ops-1:0] OP_ADD = Ops'(0);
    localparam logic [Ops-1:0] OP_LSL = Ops'(1);
    localparam logic [Ops-1:0] OP_LSR = Ops'(2);
    localparam logic [Ops-1:0] OP_MSK = Ops'(6);
    localparam logic [W-1:0]   W_SAT  = W'(W);
    localparam logic [W-1:0]   ONE    = W'(1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t         r_state;
    logic [W-1:0]   r_cnt;
    logic [Ops-1:0] r_alu_op;
    logic [W-1:0]   r_alu_a;
    logic [W-1:0]   r_alu_b;
    logic           r_rsp_valid;
    logic [W-1:0]   r_rsp_data;
    logic           r_rsp_zero;
    logic           r_rsp_parity;
    logic           r_rsp_odd;
    logic           r_rsp_err;

    logic           w_accept;
    logic           w_is_shift;
    logic           w_illegal;
    logic [W-1:0]   w_steps;

    // Request decode: shift-type ops run one 1-bit step per cycle, saturating at W steps
    always_comb begin
        w_is_shift = (i_req_op == OP_LSL) || (i_req_op == OP_LSR) || (i_req_op == OP_MSK);
        w_illegal  = (i_req_op > OP_MSK);
        w_steps    = ONE;
        if (w_is_shift) begin
            if (i_req_b >= W_SAT) begin
                w_steps = W_SAT;
            end else if (i_req_b != '0) begin
                w_steps = i_req_b;
            end
        end
    end

    assign o_req_ready = (r_state == S_IDLE) && !i_reset;
    assign w_accept    = i_req_valid && o_req_ready;

    // Control FSM; the ALU A register doubles as the accumulator between steps
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_alu_op     <= OP_ADD;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_parity <= 1'b0;
            r_rsp_odd    <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_illegal) begin
                            r_state      <= S_DONE;
                            r_rsp_valid  <= 1'b1;
                            r_rsp_data   <= '0;
                            r_rsp_zero   <= 1'b0;
                            r_rsp_parity <= 1'b0;
                            r_rsp_odd    <= 1'b0;
                            r_rsp_err    <= 1'b1;
                        end else begin
                            r_state  <= S_EXEC;
                            r_cnt    <= w_steps;
                            // MSK builds 1<<B by shifting a seed of 1 left
                            r_alu_op <= (i_req_op == OP_MSK) ? OP_LSL : i_req_op;
                            r_alu_a  <= (i_req_op == OP_MSK) ? ONE : i_req_a;
                            if (w_is_shift) begin
                                r_alu_b <= (i_req_b != '0) ? ONE : '0;
                            end else begin
                                r_alu_b <= i_req_b;
                            end
                        end
                    end
                end
                S_EXEC: begin
                    r_cnt   <= r_cnt - ONE;
                    r_alu_a <= i_alu_out;
                    if (r_cnt == ONE) begin
                        r_state      <= S_DONE;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_data   <= i_alu_out;
                        r_rsp_zero   <= i_alu_zero;
                        r_rsp_parity <= i_alu_parity;
                        r_rsp_odd    <= i_alu_odd;
                        r_rsp_err    <= 1'b0;
                        r_alu_op     <= OP_ADD;
                        r_alu_a      <= '0;
                        r_alu_b      <= '0;
                    end
                end
                S_DONE: begin
                    if (i_rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_PERF_EN
    logic [15:0] r_op_count;
    logic [15:0] r_step_count;

    // Saturating activity counters: accepted requests and EXEC cycles
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_op_count   <= '0;
            r_step_count <= '0;
        end else begin
            if (w_accept && (r_op_count != 16'hFFFF)) begin
                r_op_count <= r_op_count + 16'd1;
            end
            if ((r_state == S_EXEC) && (r_step_count != 16'hFFFF)) begin
                r_step_count <= r_step_count + 16'd1;
            end
        end
    end

    assign o_op_count   = r_op_count;
    assign o_step_count = r_step_count;
`endif

    assign o_alu_op     = r_alu_op;
    assign o_alu_a      = r_alu_a;
    assign o_alu_b      = r_alu_b;
    assign o_alu_sc     = 1'b0;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_data   = r_rsp_data;
    assign o_rsp_zero   = r_rsp_zero;
    assign o_rsp_parity = r_rsp_parity;
    assign o_rsp_odd    = r_rsp_odd;
    assign o_rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer
module tb_alu_sequencer;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [2:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_sc;
    logic [7:0] alu_out;
    logic       alu_zero;
    logic       alu_parity;
    logic       alu_odd;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_zero;
    logic       rsp_parity;
    logic       rsp_odd;
    logic       rsp_err;
`ifdef ALU_SEQ_PERF_EN
    logic [15:0] op_count;
    logic [15:0] step_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    alu_sequencer #(.W(8), .Ops(3)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_op     (req_op),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .o_alu_op     (alu_op),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_sc     (alu_sc),
        .i_alu_out    (alu_out),
        .i_alu_zero   (alu_zero),
        .i_alu_parity (alu_parity),
        .i_alu_odd    (alu_odd),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_data   (rsp_data),
        .o_rsp_zero   (rsp_zero),
        .o_rsp_parity (rsp_parity),
        .o_rsp_odd    (rsp_odd),
        .o_rsp_err    (rsp_err)
`ifdef ALU_SEQ_PERF_EN
        ,
        .o_op_count   (op_count),
        .o_step_count (step_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU attached to the sequencer
    always_comb begin
        case (alu_op)
            3'd0:    alu_out = alu_a + alu_b + {7'd0, alu_sc};
            3'd1:    alu_out = alu_a << alu_b;
            3'd2:    alu_out = alu_a >> alu_b;
            3'd3:    alu_out = alu_a ^ alu_b;
            3'd4:    alu_out = {7'd0, alu_a != alu_b};
            3'd5:    alu_out = {7'd0, alu_a == alu_b};
            default: alu_out = 8'd0;
        endcase
        alu_zero   = (alu_out == 8'd0);
        alu_parity = ^alu_out;
        alu_odd    = alu_out[0];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_shift(input logic [2:0] op);
        return (op == 3'd1) || (op == 3'd2) || (op == 3'd6);
    endfunction

    function automatic int shift_amt(input logic [7:0] b);
        return (b > 8'd8) ? 8 : int'(b);
    endfunction

    function automatic int model_steps(input logic [2:0] op, input logic [7:0] b);
        if (!is_shift(op) || b == 8'd0) return 1;
        return shift_amt(b);
    endfunction

    // Accumulator value after k single-bit shifts
    function automatic logic [7:0] acc_after(input logic [2:0] op, input logic [7:0] a, input int k);
        logic [7:0] seed;
        seed = 8'h01;
        case (op)
            3'd1:    return a << k;
            3'd2:    return a >> k;
            3'd6:    return seed << k;
            default: return a;
        endcase
    endfunction

    function automatic logic [7:0] model_result(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd3:    return a ^ b;
            3'd4:    return (a != b) ? 8'd1 : 8'd0;
            3'd5:    return (a == b) ? 8'd1 : 8'd0;
            default: return acc_after(op, a, shift_amt(b));
        endcase
    endfunction

    // Transaction-level model and per-cycle compare
    int         m_state = 0;
    int         m_k;
    int         m_n;
    logic [2:0] m_op;
    logic [7:0] m_a;
    logic [7:0] m_b;
    logic [7:0] m_res;
    logic       m_err;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rsp_flags", {rsp_zero, rsp_parity, rsp_odd}, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_alu", {alu_op, alu_a, alu_b, alu_sc}, 0);
            m_state = 0;
        end else begin
            chk("alu_sc", alu_sc, 0);
            case (m_state)
                0: begin
                    chk("idle_req_ready", req_ready, 1);
                    chk("idle_rsp_valid", rsp_valid, 0);
                    chk("idle_alu", {alu_op, alu_a, alu_b}, 0);
                    if (req_valid) begin
                        m_op = req_op;
                        m_a  = req_a;
                        m_b  = req_b;
                        m_k  = 0;
                        if (req_op == 3'd7) begin
                            m_err   = 1'b1;
                            m_res   = 8'd0;
                            m_state = 2;
                        end else begin
                            m_err   = 1'b0;
                            m_res   = model_result(req_op, req_a, req_b);
                            m_n     = model_steps(req_op, req_b);
                            m_state = 1;
                        end
                    end
                end
                1: begin
                    chk("exec_req_ready", req_ready, 0);
                    chk("exec_rsp_valid", rsp_valid, 0);
                    chk("exec_alu_op", alu_op, (m_op == 3'd6) ? 3'd1 : m_op);
                    chk("exec_alu_a", alu_a, acc_after(m_op, m_a, m_k));
                    chk("exec_alu_b", alu_b, is_shift(m_op) ? ((m_b != 0) ? 8'd1 : 8'd0) : m_b);
                    m_k++;
                    if (m_k == m_n) m_state = 2;
                end
                default: begin
                    chk("done_req_ready", req_ready, 0);
                    chk("done_rsp_valid", rsp_valid, 1);
                    chk("done_rsp_data", rsp_data, m_res);
                    chk("done_rsp_err", rsp_err, m_err);
                    chk("done_rsp_flags", {rsp_zero, rsp_parity, rsp_odd},
                        m_err ? 3'b000 : {m_res == 8'd0, ^m_res, m_res[0]});
                    chk("done_alu", {alu_op, alu_a, alu_b}, 0);
                    if (rsp_ready) m_state = 0;
                end
            endcase
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One request with literal expectations on result, flags and latency
    task automatic run_req(input string nm, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp_d, input logic [2:0] exp_zpo, input logic exp_err,
                           input int exp_lat, input int hold);
        int cyc;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        tick();
        req_valid = 1'b0;
        req_op    = 3'd3;
        req_a     = 8'hA5;
        req_b     = 8'h3C;
        cyc = 0;
        while (!rsp_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        chk({nm, "_latency"}, cyc, exp_lat);
        chk({nm, "_data"}, rsp_data, exp_d);
        chk({nm, "_flags"}, {rsp_zero, rsp_parity, rsp_odd}, exp_zpo);
        chk({nm, "_err"}, rsp_err, exp_err);
        repeat (hold) tick();
        chk({nm, "_held_data"}, rsp_data, exp_d);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({nm, "_ready_after"}, req_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = 8'd0;
        req_b     = 8'd0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        run_req("add",     3'd0, 8'h7F, 8'h01, 8'h80, 3'b010, 1'b0, 1, 0);
        run_req("lsl3",    3'd1, 8'h03, 8'd3,  8'h18, 3'b000, 1'b0, 3, 0);
        run_req("lsr9",    3'd2, 8'h80, 8'd9,  8'h00, 3'b100, 1'b0, 8, 0);
        run_req("lsl0",    3'd1, 8'h5A, 8'd0,  8'h5A, 3'b000, 1'b0, 1, 0);
        run_req("msk6",    3'd6, 8'hFF, 8'd6,  8'h40, 3'b010, 1'b0, 6, 0);
        run_req("msk0",    3'd6, 8'h77, 8'd0,  8'h01, 3'b011, 1'b0, 1, 0);
        run_req("seq",     3'd5, 8'h33, 8'h33, 8'h01, 3'b011, 1'b0, 1, 5);
        run_req("sne",     3'd4, 8'h12, 8'h34, 8'h01, 3'b011, 1'b0, 1, 0);
        run_req("addwrap", 3'd0, 8'hFF, 8'h01, 8'h00, 3'b100, 1'b0, 1, 2);
        run_req("lsl8",    3'd1, 8'hFF, 8'd8,  8'h00, 3'b100, 1'b0, 8, 0);
        run_req("illegal", 3'd7, 8'h55, 8'h66, 8'h00, 3'b000, 1'b1, 0, 1);

        // Abort an LSL by 5 partway through EXEC
        req_valid = 1'b1;
        req_op    = 3'd1;
        req_a     = 8'h01;
        req_b     = 8'd5;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rsp_valid", rsp_valid, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("abort_no_rsp", rsp_valid, 0);
        end

        run_req("xor",     3'd3, 8'hF0, 8'h0F, 8'hFF, 3'b001, 1'b0, 1, 0);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
